channel_pack_gearbox: RTL and testbench

- Packs the samples of the enabled channels from a multi-channel sample stream into dense output beats, lowest channel first, oldest input first.
- Each output beat carries NUM_CH samples, so output beats are fully packed whatever the number of enabled channels.
- Sits upstream of the timestamped pack/unpack path.
- Also reports the enabled-channel count (registered popcount of the mask) and the buffer fill level.

---
 rtl/channel_pack_gearbox.sv | 134 +++++++++++++
 tb/tb_channel_pack_gearbox.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_pack_gearbox.sv
// Packs the enabled channels of a multi-channel sample stream into dense
// NUM_CH-sample output beats through a 2*NUM_CH slot buffer; flush zero-pads a partial beat.
module channel_pack_gearbox #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              enable,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0]     s_data,
  input  logic                           flush,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_CH*SAMPLE_W-1:0]     m_data,
  output logic                           m_last,
  output logic [$clog2(NUM_CH+1)-1:0]    enable_count,
  output logic [$clog2(2*NUM_CH+1)-1:0]  fill
);

  localparam int SLOTS = 2 * NUM_CH;
  localparam int CW    = $clog2(NUM_CH + 1);
  localparam int FW    = $clog2(2 * NUM_CH + 1);
  localparam logic [FW-1:0] BEAT_F = FW'(NUM_CH);
  localparam logic [FW-1:0] FULL_F = FW'(SLOTS);

  logic [SAMPLE_W-1:0] slot_r   [SLOTS];
  logic [SAMPLE_W-1:0] slot_n_s [SLOTS];
  logic [FW-1:0]       fill_r;
  logic [1:0]          last_r;
  logic [NUM_CH-1:0]   en_q_r;
  logic [CW-1:0]       count_r;

  logic [NUM_CH-1:0]   en_sel_s;
  logic [CW-1:0]       rank_s [NUM_CH];
  logic [CW-1:0]       cnt_s;
  logic                pop_s;
  logic                acc_s;
  logic [FW-1:0]       base_s;
  logic [FW-1:0]       grow_s;
  logic [FW-1:0]       fill_n_s;
  logic [FW-1:0]       round_s;
  logic [FW-1:0]       fill_d_s;
  logic [1:0]          last_n_s;

  assign m_valid = (fill_r >= BEAT_F);
  assign s_ready = (fill_r < BEAT_F) || m_ready;
  assign pop_s   = m_valid && m_ready;
  assign acc_s   = s_valid && s_ready;

  // Active mask selection; rank_s[c] is the packed position of channel c within one input beat.
  always_comb begin
    logic [CW-1:0] run;
    en_sel_s = (fill_r == {FW{1'b0}}) ? enable : en_q_r;
    run      = {CW{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      rank_s[c] = run;
      run       = run + CW'(en_sel_s[c]);
    end
    cnt_s = run;
  end

  // Next buffer image: pop shifts beat 1 down, accept appends, flush pads the top partial beat.
  always_comb begin
    slot_n_s = slot_r;
    last_n_s = last_r;
    if (pop_s) begin
      for (int i = 0; i < NUM_CH; i++) begin
        slot_n_s[i]          = slot_r[i+NUM_CH];
        slot_n_s[i+NUM_CH]   = {SAMPLE_W{1'b0}};
      end
      last_n_s = {1'b0, last_r[1]};
      base_s   = fill_r - BEAT_F;
    end else begin
      base_s   = fill_r;
    end

    // accept only happens with base_s <= NUM_CH, so base_s + rank never wraps
    for (int i = 0; i < SLOTS; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        slot_n_s[i] = (acc_s && en_sel_s[c] && ((base_s + FW'(rank_s[c])) == FW'(i)))
                      ? s_data[c*SAMPLE_W +: SAMPLE_W] : slot_n_s[i];
      end
    end

    grow_s   = acc_s ? FW'(cnt_s) : {FW{1'b0}};
    fill_n_s = base_s + grow_s;
    round_s  = (fill_n_s <= BEAT_F) ? BEAT_F : FULL_F;

    // Only the topmost beat can be partial, so rounding targets either NUM_CH or 2*NUM_CH.
    if (flush && (fill_n_s != {FW{1'b0}}) && (fill_n_s != BEAT_F) && (fill_n_s != FULL_F)) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_n_s[i] = ((FW'(i) >= fill_n_s) && (FW'(i) < round_s)) ? {SAMPLE_W{1'b0}} : slot_n_s[i];
      end
      if (round_s == BEAT_F) begin
        last_n_s[0] = 1'b1;
      end else begin
        last_n_s[1] = 1'b1;
      end
      fill_d_s = round_s;
    end else begin
      fill_d_s = fill_n_s;
    end
  end

  // State registers with synchronous reset that discards buffered samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_r[i] <= {SAMPLE_W{1'b0}};
      end
      fill_r  <= {FW{1'b0}};
      last_r  <= 2'b00;
      en_q_r  <= {NUM_CH{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      slot_r  <= slot_n_s;
      fill_r  <= fill_d_s;
      last_r  <= last_n_s;
      en_q_r  <= en_sel_s;
      count_r <= cnt_s;
    end
  end

  for (genvar j = 0; j < NUM_CH; j++) begin : g_out
    assign m_data[j*SAMPLE_W +: SAMPLE_W] = slot_r[j];
  end

  assign m_last       = last_r[0];
  assign enable_count = count_r;
  assign fill         = fill_r;

endmodule

// File: tb/tb_channel_pack_gearbox.sv
// Bench for channel_pack_gearbox: directed vector table, hand sequences for
// flush/backpressure/mask/reset, then random traffic against a sample-queue model.
module tb_channel_pack_gearbox;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk;
  logic          reset;
  logic [N-1:0]  enable;
  logic          s_valid;
  logic          s_ready;
  logic [N*W-1:0] s_data;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [N*W-1:0] m_data;
  logic          m_last;
  logic [2:0]    enable_count;
  logic [3:0]    fill;

  int n_vec = 0;
  int n_err = 0;

  channel_pack_gearbox #(.NUM_CH(N), .SAMPLE_W(W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .enable_count(enable_count), .fill(fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of samples, each tagged as real or flush padding.
  typedef struct { logic [W-1:0] d; bit pad; } smp_t;
  smp_t         mq[$];
  logic [N-1:0] m_en = '0;
  int           m_cnt = 0;

  task automatic model_step();
    int f;
    logic [N-1:0] sel;
    smp_t s;
    f = mq.size();
    if (reset) begin
      mq.delete();
      m_en  = '0;
      m_cnt = 0;
    end else begin
      sel = (f == 0) ? enable : m_en;
      if ((f >= N) && m_ready) begin
        for (int k = 0; k < N; k++) void'(mq.pop_front());
      end
      if (s_valid && ((f < N) || m_ready)) begin
        for (int c = 0; c < N; c++) begin
          if (sel[c]) begin
            s.d = s_data[c*W +: W];
            s.pad = 1'b0;
            mq.push_back(s);
          end
        end
      end
      if (flush) begin
        while ((mq.size() % N) != 0) begin
          s.d = '0;
          s.pad = 1'b1;
          mq.push_back(s);
        end
      end
      m_en  = sel;
      m_cnt = $countones(sel);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic [N-1:0] en, input logic sv,
                        input logic [N*W-1:0] sd, input logic fl, input logic mr);
    reset = r; enable = en; s_valid = sv; s_data = sd; flush = fl; m_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic model_check();
    int f;
    logic [N*W-1:0] md;
    bit ml;
    f = mq.size();
    chk("rnd fill", 64'(fill), 64'(f));
    chk("rnd m_valid", 64'(m_valid), 64'(f >= N));
    chk("rnd s_ready", 64'(s_ready), 64'((f < N) || m_ready));
    chk("rnd enable_count", 64'(enable_count), 64'(m_cnt));
    if (f >= N) begin
      md = '0;
      ml = 1'b0;
      for (int j = 0; j < N; j++) begin
        md[j*W +: W] = mq[j].d;
        ml = ml | mq[j].pad;
      end
      chk("rnd m_data", 64'(m_data), 64'(md));
      chk("rnd m_last", 64'(m_last), 64'(ml));
    end
  endtask

  typedef struct {
    logic           rst;
    logic [N-1:0]   en;
    logic           sv;
    logic [N*W-1:0] sd;
    logic           fl;
    logic           mr;
    logic           e_sr;
    logic           e_mv;
    logic [N*W-1:0] e_md;
    logic           e_ml;
    logic [2:0]     e_cnt;
    logic [3:0]     e_fill;
  } vec_t;

  vec_t tbl [14];

  logic [N*W-1:0] d1, d2, d3;

  initial begin
    // expectations are the state seen before the row's clock edge
    tbl[0]  = '{1'b0, 4'hF, 1'b1, 64'h0003_0002_0001_0000, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3'd0, 4'd0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 64'h0013_0012_0011_0010, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0003_0002_0001_0000, 1'b0, 3'd4, 4'd4};
    tbl[2]  = '{1'b0, 4'hF, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0013_0012_0011_0010, 1'b0, 3'd4, 4'd4};
    tbl[3]  = '{1'b0, 4'h5, 1'b1, 64'h000D_000C_000B_000A, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3'd4, 4'd0};
    tbl[4]  = '{1'b0, 4'h5, 1'b1, 64'h001D_001C_001B_001A, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3'd2, 4'd2};
    tbl[5]  = '{1'b0, 4'h5, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h001C_001A_000C_000A, 1'b0, 3'd2, 4'd4};
    tbl[6]  = '{1'b0, 4'h5, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h001C_001A_000C_000A, 1'b0, 3'd2, 4'd4};
    tbl[7]  = '{1'b0, 4'h7, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3'd2, 4'd0};
    tbl[8]  = '{1'b0, 4'h7, 1'b1, 64'h0003_0002_0001_0000, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3'd3, 4'd0};
    tbl[9]  = '{1'b0, 4'h7, 1'b1, 64'h0013_0012_0011_0010, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3'd3, 4'd3};
    tbl[10] = '{1'b0, 4'h7, 1'b1, 64'h0023_0022_0021_0020, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0010_0002_0001_0000, 1'b0, 3'd3, 4'd6};
    tbl[11] = '{1'b0, 4'h7, 1'b1, 64'h0033_0032_0031_0030, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0021_0020_0012_0011, 1'b0, 3'd3, 4'd5};
    tbl[12] = '{1'b0, 4'h7, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0032_0031_0030_0022, 1'b0, 3'd3, 4'd4};
    tbl[13] = '{1'b0, 4'h7, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3'd3, 4'd0};

    set_in(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset s_ready", 64'(s_ready), 64'd1);
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset m_last", 64'(m_last), 64'd0);
    chk("reset m_data", 64'(m_data), 64'd0);
    chk("reset enable_count", 64'(enable_count), 64'd0);
    chk("reset fill", 64'(fill), 64'd0);
    tick();

    // Pass-through, half mask and 3-of-4 mask vectors
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].rst, tbl[i].en, tbl[i].sv, tbl[i].sd, tbl[i].fl, tbl[i].mr);
      @(negedge clk);
      chk($sformatf("tbl%0d s_ready", i), 64'(s_ready), 64'(tbl[i].e_sr));
      chk($sformatf("tbl%0d m_valid", i), 64'(m_valid), 64'(tbl[i].e_mv));
      chk($sformatf("tbl%0d enable_count", i), 64'(enable_count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d fill", i), 64'(fill), 64'(tbl[i].e_fill));
      if (tbl[i].e_mv) begin
        chk($sformatf("tbl%0d m_data", i), 64'(m_data), 64'(tbl[i].e_md));
        chk($sformatf("tbl%0d m_last", i), 64'(m_last), 64'(tbl[i].e_ml));
      end
      tick();
    end

    // Flush of a partial beat, then flush with an empty buffer
    set_in(1'b1, '0, 1'b0, '0, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'h3, 1'b1, 64'h0077_0066_00BB_00AA, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'h3, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush pre fill", 64'(fill), 64'd2);
    chk("flush pre m_valid", 64'(m_valid), 64'd0);
    tick();
    set_in(1'b0, 4'h3, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush m_valid", 64'(m_valid), 64'd1);
    chk("flush m_data", 64'(m_data), 64'h0000_0000_00BB_00AA);
    chk("flush m_last", 64'(m_last), 64'd1);
    chk("flush fill", 64'(fill), 64'd4);
    tick();
    set_in(1'b0, 4'h3, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush hold m_data", 64'(m_data), 64'h0000_0000_00BB_00AA);
    chk("flush hold m_last", 64'(m_last), 64'd1);
    tick();
    set_in(1'b0, 4'h3, 1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush drained fill", 64'(fill), 64'd0);
    tick();
    set_in(1'b0, 4'h3, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("empty flush m_valid", 64'(m_valid), 64'd0);
    chk("empty flush fill", 64'(fill), 64'd0);
    tick();

    // Backpressure: a held beat blocks input until m_ready rises
    d1 = 64'h0103_0102_0101_0100;
    d2 = 64'h0203_0202_0201_0200;
    d3 = 64'h0303_0302_0301_0300;
    set_in(1'b1, '0, 1'b0, '0, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'hF, 1'b1, d1, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp s_ready empty", 64'(s_ready), 64'd1);
    tick();
    set_in(1'b0, 4'hF, 1'b1, d2, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp s_ready full", 64'(s_ready), 64'd0);
    chk("bp m_data d1", 64'(m_data), 64'(d1));
    tick();
    @(negedge clk);
    chk("bp stall s_ready", 64'(s_ready), 64'd0);
    chk("bp stall m_data", 64'(m_data), 64'(d1));
    chk("bp stall fill", 64'(fill), 64'd4);
    tick();
    set_in(1'b0, 4'hF, 1'b1, d2, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp release s_ready", 64'(s_ready), 64'd1);
    chk("bp release m_data", 64'(m_data), 64'(d1));
    tick();
    set_in(1'b0, 4'hF, 1'b1, d3, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp beat2", 64'(m_data), 64'(d2));
    tick();
    set_in(1'b0, 4'hF, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp beat3", 64'(m_data), 64'(d3));
    chk("bp beat3 m_valid", 64'(m_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("bp drained m_valid", 64'(m_valid), 64'd0);
    chk("bp drained fill", 64'(fill), 64'd0);
    tick();

    // Mask change held off while buffer is non-empty, then reset and an empty mask
    set_in(1'b1, '0, 1'b0, '0, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'h1, 1'b1, 64'h0004_0003_0002_0001, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'hF, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mask enable_count", 64'(enable_count), 64'd1);
    chk("mask fill", 64'(fill), 64'd1);
    tick();
    @(negedge clk);
    chk("mask held enable_count", 64'(enable_count), 64'd1);
    set_in(1'b1, 4'hF, 1'b0, '0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 4'h0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst mid fill", 64'(fill), 64'd0);
    chk("rst mid m_valid", 64'(m_valid), 64'd0);
    chk("rst mid s_ready", 64'(s_ready), 64'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 4'h0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      @(negedge clk);
      chk("zero mask s_ready", 64'(s_ready), 64'd1);
      tick();
    end
    set_in(1'b0, 4'h0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("zero mask fill", 64'(fill), 64'd0);
    chk("zero mask m_valid", 64'(m_valid), 64'd0);
    chk("zero mask enable_count", 64'(enable_count), 64'd0);
    tick();

    // Random traffic against the queue model
    set_in(1'b1, '0, 1'b0, '0, 1'b0, 1'b0); tick();
    begin
      logic [N-1:0] en_v;
      en_v = 4'hF;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if ($urandom_range(0, 7) == 0) en_v = 4'($urandom_range(0, 15));
        set_in($urandom_range(0, 299) == 0, en_v, $urandom_range(0, 9) < 7,
               {$urandom, $urandom}, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
        @(negedge clk);
        model_check();
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
